// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size codes, FSM states, lane lookup.
package lsu_pkg;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;
    localparam logic [1:0] MASK_X = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_ISSUE1,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    typedef struct packed {
        logic [2:0] size;
        logic [3:0] mask;
    } lane_t;

    // Access size in bytes and the unshifted byte mask for a maskmode code.
    function automatic lane_t mm_lane(input logic [1:0] mm);
        lane_t l;
        case (mm)
            MASK_B:  l = '{size: 3'd1, mask: 4'b0001};
            MASK_H:  l = '{size: 3'd2, mask: 4'b0011};
            MASK_W:  l = '{size: 3'd4, mask: 4'b1111};
            default: l = '{size: 3'd0, mask: 4'b0000};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request/response and data-memory port of the load/store unit.
interface lsu_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_SIZE = 8
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [1:0]               req_maskmode;
    logic                     req_sext;
    logic [DATA_WIDTH-1:0]    req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     resp_valid;
    logic [DATA_WIDTH-1:0]    resp_rdata;
    logic                     resp_err;
    logic                     mem_en;
    logic                     mem_we;
    logic [MEM_ADDR_SIZE-1:0] mem_addr;
    logic [3:0]               mem_be;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (
        output req_valid, req_write, req_maskmode, req_sext, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_maskmode, req_sext, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Lane alignment: store shift and byte enables across two words, load merge and extend.
// Purely combinational; no latency, no backpressure.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            maskmode,
    input  logic                  sext,
    input  logic [1:0]            off,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] word0,
    input  logic [DATA_WIDTH-1:0] word1,
    output logic                  split,
    output logic [3:0]            be_lo,
    output logic [3:0]            be_hi,
    output logic [DATA_WIDTH-1:0] wdata_lo,
    output logic [DATA_WIDTH-1:0] wdata_hi,
    output logic [DATA_WIDTH-1:0] rdata
);
    lane_t                   lane;
    logic [7:0]              be_wide;
    logic [2*DATA_WIDTH-1:0] wide_st;
    logic [DATA_WIDTH-1:0]   shifted;

    always_comb begin
        lane     = mm_lane(maskmode);
        split    = ({1'b0, off} + lane.size) > 3'd4;
        be_wide  = {4'b0000, lane.mask} << off;
        be_lo    = be_wide[3:0];
        be_hi    = be_wide[7:4];
        wide_st  = {{DATA_WIDTH{1'b0}}, wdata} << {off, 3'b000};
        wdata_lo = wide_st[DATA_WIDTH-1:0];
        wdata_hi = wide_st[2*DATA_WIDTH-1:DATA_WIDTH];
        shifted  = DATA_WIDTH'({word1, word0} >> {off, 3'b000});
        // sext is inverted: 0 selects sign extension.
        case (maskmode)
            MASK_B:  rdata = sext ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                  : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            MASK_H:  rdata = sext ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                  : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, split across two word accesses when unaligned.
// Latency 1 (illegal) to 4 (split load) cycles after accept; req_ready only in IDLE, no resp backpressure.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_SIZE = 8
) (
    input  logic  clk,
    input  logic  rstn,
    lsu_if.slave  bus
);
    localparam logic [MEM_ADDR_SIZE-1:0] IDX_ONE = 1;

    lsu_state_t               state;
    logic                     r_write;
    logic [1:0]               r_mm;
    logic                     r_sext;
    logic [MEM_ADDR_SIZE+1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    word0_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;

    logic [MEM_ADDR_SIZE-1:0] idx0, idx1;
    logic [DATA_WIDTH-1:0]    al_word0;
    logic                     split;
    logic [3:0]               be_lo, be_hi;
    logic [DATA_WIDTH-1:0]    wdata_lo, wdata_hi, ld_result;
    logic [DATA_WIDTH-MEM_ADDR_SIZE-3:0] unused_addr;

    assign unused_addr = bus.req_addr[DATA_WIDTH-1:MEM_ADDR_SIZE+2];
    assign idx0        = r_addr[MEM_ADDR_SIZE+1:2];
    assign idx1        = idx0 + IDX_ONE;
    // In WAIT the freshly read word is word0 unless the access was split.
    assign al_word0    = (state == ST_WAIT && !split) ? bus.mem_rdata : word0_q;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .maskmode (r_mm),
        .sext     (r_sext),
        .off      (r_addr[1:0]),
        .wdata    (r_wdata),
        .word0    (al_word0),
        .word1    (bus.mem_rdata),
        .split    (split),
        .be_lo    (be_lo),
        .be_hi    (be_hi),
        .wdata_lo (wdata_lo),
        .wdata_hi (wdata_hi),
        .rdata    (ld_result)
    );

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_DONE);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = '0;
        case (state)
            ST_ISSUE0: begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = r_write;
                bus.mem_addr = idx0;
                if (r_write) begin
                    bus.mem_be    = be_lo;
                    bus.mem_wdata = wdata_lo;
                end
            end
            ST_ISSUE1: begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = r_write;
                bus.mem_addr = idx1;
                if (r_write) begin
                    bus.mem_be    = be_hi;
                    bus.mem_wdata = wdata_hi;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            r_write <= 1'b0;
            r_mm    <= MASK_B;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            word0_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    r_write <= bus.req_write;
                    r_mm    <= bus.req_maskmode;
                    r_sext  <= bus.req_sext;
                    r_addr  <= bus.req_addr[MEM_ADDR_SIZE+1:0];
                    r_wdata <= bus.req_wdata;
                    if (bus.req_maskmode == MASK_X) begin
                        state   <= ST_DONE;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        state <= ST_ISSUE0;
                    end
                end
                ST_ISSUE0: begin
                    if (split) begin
                        state <= ST_ISSUE1;
                    end else if (r_write) begin
                        state   <= ST_DONE;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_ISSUE1: begin
                    word0_q <= bus.mem_rdata;
                    if (r_write) begin
                        state   <= ST_DONE;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state   <= ST_DONE;
                    rdata_q <= ld_result;
                    err_q   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-enabled synchronous-read memory model.
module tb_load_store_unit;
    logic clk;
    logic rstn;

    lsu_if #(.DATA_WIDTH(32), .MEM_ADDR_SIZE(8)) bus ();

    load_store_unit #(.DATA_WIDTH(32), .MEM_ADDR_SIZE(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [7:0]  tr_addr [0:3];
    logic [3:0]  tr_be   [0:3];
    logic [31:0] tr_wd   [0:3];
    logic        tr_we   [0:3];

    task automatic do_req(input logic w, input logic [1:0] mm, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int nacc,
                          output logic [31:0] rd, output logic err);
        lat = -1; nacc = 0; rd = 32'hx; err = 1'bx;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_maskmode = mm;
        bus.req_sext     = sx;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                if (nacc < 4) begin
                    tr_addr[nacc] = bus.mem_addr;
                    tr_be[nacc]   = bus.mem_be;
                    tr_wd[nacc]   = bus.mem_wdata;
                    tr_we[nacc]   = bus.mem_we;
                end
                nacc++;
            end
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_rdata;
                err = bus.resp_err;
                break;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  mm;
        logic        sx;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    function automatic vec_t mk(input string n, input logic w, input logic [1:0] mm,
                                input logic sx, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic ee, input int el, input int ea);
        vec_t v;
        v.name = n; v.w = w; v.mm = mm; v.sx = sx; v.a = a; v.d = d;
        v.exp_rd = er; v.exp_err = ee; v.exp_lat = el; v.exp_acc = ea;
        return v;
    endfunction

    vec_t vecs[$];
    int lat, nacc;
    logic [31:0] rd;
    logic err;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // store-word / load-word / byte / half (sext=0 sign, 1 zero)
        vecs.push_back(mk("sw_10",     1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 0, 0, 2, 1));
        vecs.push_back(mk("lw_10",     0, 2'b10, 0, 32'h10,  0, 32'hDEADBEEF, 0, 3, 1));
        vecs.push_back(mk("sw_10b",    1, 2'b10, 0, 32'h10,  32'h80123456, 0, 0, 2, 1));
        vecs.push_back(mk("lb_13_s",   0, 2'b00, 0, 32'h13,  0, 32'hFFFFFF80, 0, 3, 1));
        vecs.push_back(mk("lb_13_z",   0, 2'b00, 1, 32'h13,  0, 32'h00000080, 0, 3, 1));
        vecs.push_back(mk("lb_10_s",   0, 2'b00, 0, 32'h10,  0, 32'h00000056, 0, 3, 1));
        vecs.push_back(mk("lh_12_s",   0, 2'b01, 0, 32'h12,  0, 32'hFFFF8012, 0, 3, 1));
        vecs.push_back(mk("lh_11_z",   0, 2'b01, 1, 32'h11,  0, 32'h00001234, 0, 3, 1));
        vecs.push_back(mk("lw_sx1",    0, 2'b10, 1, 32'h10,  0, 32'h80123456, 0, 3, 1));
        vecs.push_back(mk("lw_hiaddr", 0, 2'b10, 0, 32'h10000010, 0, 32'h80123456, 0, 3, 1));
        vecs.push_back(mk("sw_20",     1, 2'b10, 0, 32'h20,  32'hAB000000, 0, 0, 2, 1));
        vecs.push_back(mk("sw_24",     1, 2'b10, 0, 32'h24,  32'h000000CD, 0, 0, 2, 1));
        vecs.push_back(mk("sw_28",     1, 2'b10, 0, 32'h28,  32'h00000000, 0, 0, 2, 1));
        vecs.push_back(mk("lh_23_spl", 0, 2'b01, 0, 32'h23,  0, 32'hFFFFCDAB, 0, 4, 2));
        vecs.push_back(mk("sh_27_spl", 1, 2'b01, 0, 32'h27,  32'h1234BEEF, 0, 0, 3, 2));
        vecs.push_back(mk("lw_24",     0, 2'b10, 0, 32'h24,  0, 32'hEF0000CD, 0, 3, 1));
        vecs.push_back(mk("lw_28",     0, 2'b10, 0, 32'h28,  0, 32'h000000BE, 0, 3, 1));
        vecs.push_back(mk("lw_26_spl", 0, 2'b10, 0, 32'h26,  0, 32'h00BEEF00, 0, 4, 2));
        vecs.push_back(mk("sw_30",     1, 2'b10, 0, 32'h30,  32'hFFFFFFFF, 0, 0, 2, 1));
        vecs.push_back(mk("sb_31",     1, 2'b00, 0, 32'h31,  32'h123456A5, 0, 0, 2, 1));
        vecs.push_back(mk("lw_30",     0, 2'b10, 0, 32'h30,  0, 32'hFFFFA5FF, 0, 3, 1));
        vecs.push_back(mk("illegal",   0, 2'b11, 0, 32'h10,  32'h55555555, 0, 1, 1, 0));
        vecs.push_back(mk("after_ill", 0, 2'b10, 0, 32'h10,  0, 32'h80123456, 0, 3, 1));
        vecs.push_back(mk("sw_3fc",    1, 2'b10, 0, 32'h3FC, 32'h00000000, 0, 0, 2, 1));
        vecs.push_back(mk("sw_000",    1, 2'b10, 0, 32'h000, 32'h00000000, 0, 0, 2, 1));
        vecs.push_back(mk("sw_40",     1, 2'b10, 0, 32'h40,  32'hAAAAAAAA, 0, 0, 2, 1));
        vecs.push_back(mk("sw_44",     1, 2'b10, 0, 32'h44,  32'hAAAAAAAA, 0, 0, 2, 1));

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_maskmode = 2'b00;
        bus.req_sext = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #2;
        chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
        chk("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
        chk("rst_mem_en",     {31'b0, bus.mem_en},     32'd0);
        chk("rst_mem_we",     {31'b0, bus.mem_we},     32'd0);
        chk("rst_mem_be",     {28'b0, bus.mem_be},     32'd0);
        chk("rst_mem_addr",   {24'b0, bus.mem_addr},   32'd0);
        chk("rst_mem_wdata",  bus.mem_wdata,           32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            do_req(vecs[i].w, vecs[i].mm, vecs[i].sx, vecs[i].a, vecs[i].d, lat, nacc, rd, err);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            chk({vecs[i].name, "_acc"}, nacc, vecs[i].exp_acc);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
            chk({vecs[i].name, "_err"}, {31'b0, err}, {31'b0, vecs[i].exp_err});
            if (vecs[i].w && nacc >= 1) chk({vecs[i].name, "_we0"}, {31'b0, tr_we[0]}, 32'd1);
        end

        // Error flag and zero data hold after an illegal request completes.
        do_req(0, 2'b11, 0, 32'h0, 32'h0, lat, nacc, rd, err);
        @(negedge clk);
        chk("ill_hold_err",   {31'b0, bus.resp_err},   32'd1);
        chk("ill_hold_valid", {31'b0, bus.resp_valid}, 32'd0);

        // Split store wrapping from the last word to word 0.
        do_req(1, 2'b10, 0, 32'h3FE, 32'h11223344, lat, nacc, rd, err);
        chk("wrap_lat",   lat, 3);
        chk("wrap_acc",   nacc, 2);
        chk("wrap_a0",    {24'b0, tr_addr[0]}, 32'd255);
        chk("wrap_be0",   {28'b0, tr_be[0]}, 32'b1100);
        chk("wrap_wd0",   tr_wd[0], 32'h33440000);
        chk("wrap_a1",    {24'b0, tr_addr[1]}, 32'd0);
        chk("wrap_be1",   {28'b0, tr_be[1]}, 32'b0011);
        chk("wrap_wd1",   tr_wd[1], 32'h00001122);
        chk("wrap_we1",   {31'b0, tr_we[1]}, 32'd1);
        do_req(0, 2'b10, 0, 32'h3FC, 0, lat, nacc, rd, err);
        chk("wrap_rd255", rd, 32'h33440000);
        do_req(0, 2'b10, 0, 32'h000, 0, lat, nacc, rd, err);
        chk("wrap_rd0",   rd, 32'h00001122);
        do_req(0, 2'b10, 0, 32'h3FE, 0, lat, nacc, rd, err);
        chk("wrap_ld",    rd, 32'h11223344);
        chk("wrap_ld_a0", {24'b0, tr_addr[0]}, 32'd255);
        chk("wrap_ld_a1", {24'b0, tr_addr[1]}, 32'd0);
        chk("wrap_ld_be", {28'b0, tr_be[0]}, 32'd0);

        // Split halfword load issues word 8 then word 9.
        do_req(0, 2'b01, 0, 32'h23, 0, lat, nacc, rd, err);
        chk("lh_spl_a0", {24'b0, tr_addr[0]}, 32'd8);
        chk("lh_spl_a1", {24'b0, tr_addr[1]}, 32'd9);

        // Reset while the second half of a split store is on the bus.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_maskmode = 2'b10;
        bus.req_sext = 1'b0; bus.req_addr = 32'h42; bus.req_wdata = 32'h11223344;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_en_before",  {31'b0, bus.mem_en}, 32'd1);
        chk("rst_mid_a_before",   {24'b0, bus.mem_addr}, 32'd17);
        rstn = 1'b0;
        #1;
        chk("rst_mid_en",    {31'b0, bus.mem_en},    32'd0);
        chk("rst_mid_be",    {28'b0, bus.mem_be},    32'd0);
        chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_mid_ready2", {31'b0, bus.req_ready}, 32'd1);
        do_req(0, 2'b10, 0, 32'h40, 0, lat, nacc, rd, err);
        chk("rst_mid_w0",     rd, 32'h3344AAAA);
        chk("rst_mid_w0_lat", lat, 3);
        do_req(0, 2'b10, 0, 32'h44, 0, lat, nacc, rd, err);
        chk("rst_mid_w1",     rd, 32'hAAAAAAAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
